// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared state encoding, port indices and round-robin pick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    // On a tie the port that was not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end else if (req1) begin
            return PORT_DATA;
        end else begin
            return PORT_IFETCH;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_2d.sv
// ============================================================================
// Module      : mux_2d
// Description : Two-input, parameterised-width steering multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_2d #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory between fetch and data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          we0,
    input  logic [W-1:0]  wdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [W-1:0]  wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [W-1:0]  rdata,
    output logic          mux_ctl,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [W-1:0]  mem_wdata,
    input  logic          mem_ack,
    input  logic [W-1:0]  mem_rdata
);

    logic [1:0]   state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q,  last_d;
    logic [W-1:0] rdata_q, rdata_d;

    logic w_busy;
    logic w_resp;
    logic w_sel_we;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = rr_pick(req0, req1, last_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    last_d  = owner_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= PORT_IFETCH;
            last_q  <= PORT_DATA;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    assign w_busy = (state_q == BUSY);
    assign w_resp = (state_q == RESP);

    // Grant covers the whole ownership window, done only the response cycle.
    assign gnt0    = (w_busy || w_resp) && (owner_q == PORT_IFETCH);
    assign gnt1    = (w_busy || w_resp) && (owner_q == PORT_DATA);
    assign done0   = w_resp && (owner_q == PORT_IFETCH);
    assign done1   = w_resp && (owner_q == PORT_DATA);
    assign rdata   = rdata_q;
    assign mux_ctl = owner_q;
    assign mem_req = w_busy;
    assign mem_we  = w_sel_we && w_busy;

    mux_2d #(.WIDTH(AW)) u_addr_mux (
        .d0_i  (addr0),
        .d1_i  (addr1),
        .sel_i (mux_ctl),
        .y_o   (mem_addr)
    );

    mux_2d #(.WIDTH(W)) u_wdata_mux (
        .d0_i  (wdata0),
        .d1_i  (wdata1),
        .sel_i (mux_ctl),
        .y_o   (mem_wdata)
    );

    mux_2d #(.WIDTH(1)) u_we_mux (
        .d0_i  (we0),
        .d1_i  (we1),
        .sel_i (mux_ctl),
        .y_o   (w_sel_we)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: directed scenarios plus randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [W-1:0]  wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1;
    logic [W-1:0]  rdata;
    logic          mux_ctl, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .we0       (we0),
        .wdata0    (wdata0),
        .req1      (req1),
        .addr1     (addr1),
        .we1       (we1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .mux_ctl   (mux_ctl),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({gnt0, gnt1, done0, done1, mem_req, mem_we, mux_ctl} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0000000", {gnt0, gnt1, done0, done1, mem_req, mem_we, mux_ctl});
        end
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got mem_req=%b want 0", mem_req);
        end
    endtask

    task automatic test_single_fetch();
        req0 = 1; addr0 = 32'h0040_0000; we0 = 0; wdata0 = $urandom;
        tick();
        total++;
        if ({mem_req, gnt0, gnt1, mem_we, mux_ctl} !== 5'b11000) begin
            bad++;
            $display("FAIL fetch_c1: got %b want 11000", {mem_req, gnt0, gnt1, mem_we, mux_ctl});
        end
        total++;
        if (mem_addr !== 32'h0040_0000) begin
            bad++;
            $display("FAIL fetch_addr: got %h want 00400000", mem_addr);
        end
        tick();
        total++;
        if ({mem_req, done0, done1} !== 3'b100) begin
            bad++;
            $display("FAIL fetch_c2: got %b want 100", {mem_req, done0, done1});
        end
        mem_ack = 1; mem_rdata = 32'h2008_0005;
        tick();
        mem_ack = 0;
        total++;
        if ({done0, done1, mem_req, gnt0} !== 4'b1001) begin
            bad++;
            $display("FAIL fetch_c3: got %b want 1001", {done0, done1, mem_req, gnt0});
        end
        total++;
        if (rdata !== 32'h2008_0005) begin
            bad++;
            $display("FAIL fetch_rdata: got %h want 20080005", rdata);
        end
        req0 = 0;
        tick();
        total++;
        if ({done0, done1, gnt0, gnt1, mem_req} !== 5'b0) begin
            bad++;
            $display("FAIL fetch_c4: got %b want 00000", {done0, done1, gnt0, gnt1, mem_req});
        end
    endtask

    task automatic test_store();
        logic [W-1:0] r;
        r = $urandom;
        req1 = 1; we1 = 1; addr1 = 32'h1000_0004; wdata1 = 32'hDEAD_BEEF;
        tick();
        total++;
        if ({mem_req, mem_we, mux_ctl, gnt1, gnt0} !== 5'b11110) begin
            bad++;
            $display("FAIL store_ctl: got %b want 11110", {mem_req, mem_we, mux_ctl, gnt1, gnt0});
        end
        total++;
        if ({mem_addr, mem_wdata} !== {32'h1000_0004, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL store_bus: got %h/%h want 10000004/deadbeef", mem_addr, mem_wdata);
        end
        mem_ack = 1; mem_rdata = r;
        tick();
        mem_ack = 0;
        total++;
        if ({done1, done0, mem_we, mem_req} !== 4'b1000) begin
            bad++;
            $display("FAIL store_done: got %b want 1000", {done1, done0, mem_we, mem_req});
        end
        total++;
        if (rdata !== r) begin
            bad++;
            $display("FAIL store_rdata: got %h want %h", rdata, r);
        end
        req1 = 0; we1 = 0;
        tick();
        total++;
        if ({done1, gnt1} !== 2'b00) begin
            bad++;
            $display("FAIL store_once: got %b want 00", {done1, gnt1});
        end
    endtask

    task automatic test_stray_ack();
        logic [W-1:0] keep;
        keep = rdata;
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 0;
        total++;
        if ({done0, done1, mem_req, gnt0, gnt1} !== 5'b0) begin
            bad++;
            $display("FAIL stray_ctl: got %b want 00000", {done0, done1, mem_req, gnt0, gnt1});
        end
        total++;
        if (rdata !== keep) begin
            bad++;
            $display("FAIL stray_rdata: got %h want %h", rdata, keep);
        end
        req0 = 1; addr0 = 32'h0000_0100;
        tick();
        total++;
        if ({mem_req, gnt0} !== 2'b11) begin
            bad++;
            $display("FAIL stray_still_idle: got %b want 11", {mem_req, gnt0});
        end
        mem_ack = 1; mem_rdata = $urandom;
        tick();
        mem_ack = 0; req0 = 0;
        tick();
    endtask

    task automatic test_back_to_back_tie();
        logic exp;
        pulse_reset();
        exp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0 = 1; req1 = 1;
            addr0 = 32'h0000_1000 + i; addr1 = 32'h0000_2000 + i;
            tick();
            total++;
            if ({gnt1, gnt0, mux_ctl} !== (exp ? 3'b101 : 3'b010)) begin
                bad++;
                $display("FAIL tie_gnt%0d: got %b want %b", i, {gnt1, gnt0, mux_ctl}, (exp ? 3'b101 : 3'b010));
            end
            total++;
            if (mem_addr !== (exp ? addr1 : addr0)) begin
                bad++;
                $display("FAIL tie_addr%0d: got %h want %h", i, mem_addr, (exp ? addr1 : addr0));
            end
            mem_ack = 1; mem_rdata = $urandom;
            tick();
            mem_ack = 0;
            total++;
            if ({done1, done0, gnt1 & gnt0} !== (exp ? 3'b100 : 3'b010)) begin
                bad++;
                $display("FAIL tie_done%0d: got %b want %b", i, {done1, done0, gnt1 & gnt0}, (exp ? 3'b100 : 3'b010));
            end
            if (exp) req1 = 0; else req0 = 0;
            if (i == 2) begin
                req0 = 0; req1 = 0;
            end
            tick();
            exp = ~exp;
        end
    endtask

    task automatic test_no_preempt();
        req0 = 1; addr0 = 32'h0000_3000;
        tick();
        req1 = 1; addr1 = 32'h0000_4000;
        tick();
        total++;
        if ({gnt0, gnt1, mux_ctl, mem_req} !== 4'b1001 || mem_addr !== 32'h0000_3000) begin
            bad++;
            $display("FAIL preempt_busy: got %b/%h want 1001/00003000", {gnt0, gnt1, mux_ctl, mem_req}, mem_addr);
        end
        mem_ack = 1; mem_rdata = $urandom;
        tick();
        mem_ack = 0;
        total++;
        if ({done0, gnt1, mux_ctl} !== 3'b100) begin
            bad++;
            $display("FAIL preempt_resp: got %b want 100", {done0, gnt1, mux_ctl});
        end
        req0 = 0;
        tick();
        total++;
        if ({mem_req, gnt1, mux_ctl} !== 3'b000) begin
            bad++;
            $display("FAIL preempt_idle: got %b want 000", {mem_req, gnt1, mux_ctl});
        end
        tick();
        total++;
        if ({mem_req, gnt1, mux_ctl} !== 3'b111 || mem_addr !== 32'h0000_4000) begin
            bad++;
            $display("FAIL preempt_switch: got %b/%h want 111/00004000", {mem_req, gnt1, mux_ctl}, mem_addr);
        end
        mem_ack = 1; mem_rdata = $urandom;
        tick();
        mem_ack = 0; req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        req0 = 1; addr0 = 32'h0000_5000;
        tick();
        total++;
        if (mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rstbusy_pre: got mem_req=%b want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_req, gnt0, gnt1} !== 3'b000) begin
            bad++;
            $display("FAIL rstbusy_async: got %b want 000", {mem_req, gnt0, gnt1});
        end
        tick();
        rst_n = 1'b1; req0 = 0;
        mem_ack = 1; mem_rdata = 32'h0000_CAFE;
        tick();
        mem_ack = 0;
        total++;
        if ({done0, done1, mem_req} !== 3'b000 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL rstbusy_late_ack: got %b/%h want 000/00000000", {done0, done1, mem_req}, rdata);
        end
        req0 = 1; req1 = 1;
        tick();
        total++;
        if ({gnt0, gnt1, mux_ctl} !== 3'b100) begin
            bad++;
            $display("FAIL rstbusy_tie: got %b want 100", {gnt0, gnt1, mux_ctl});
        end
        mem_ack = 1; mem_rdata = $urandom;
        tick();
        mem_ack = 0; req0 = 0; req1 = 0;
        tick();
    endtask

    // Transaction-level model: pending requests, last-served port, expected read data.
    task automatic test_random();
        logic          p [2];
        logic          we_m [2];
        logic [AW-1:0] a_m [2];
        logic [W-1:0]  wd_m [2];
        logic          m_last;
        logic          win;
        logic [W-1:0]  exp_rdata;
        logic [W-1:0]  r;
        int            d;
        pulse_reset();
        m_last = 1'b1;
        exp_rdata = '0;
        p[0] = 0; p[1] = 0;
        for (int k = 0; k < 2; k++) begin
            we_m[k] = 0; a_m[k] = '0; wd_m[k] = '0;
        end
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p[k] && ($urandom_range(0, 2) != 0)) begin
                    p[k] = 1;
                    we_m[k] = 1'($urandom_range(0, 1));
                    a_m[k] = $urandom;
                    wd_m[k] = $urandom;
                end
            end
            req0 = p[0]; we0 = we_m[0]; addr0 = a_m[0]; wdata0 = wd_m[0];
            req1 = p[1]; we1 = we_m[1]; addr1 = a_m[1]; wdata1 = wd_m[1];
            if (!p[0] && !p[1]) begin
                mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                tick();
                mem_ack = 0;
                total++;
                if ({mem_req, done0, done1} !== 3'b000 || rdata !== exp_rdata) begin
                    bad++;
                    $display("FAIL rnd_idle%0d: got %b/%h want 000/%h", n, {mem_req, done0, done1}, rdata, exp_rdata);
                end
                continue;
            end
            win = (p[0] && p[1]) ? ~m_last : p[1];
            tick();
            total++;
            if ({mem_req, gnt1, gnt0, mux_ctl, mem_we} !== {1'b1, win, ~win, win, we_m[win]}) begin
                bad++;
                $display("FAIL rnd_grant%0d: got %b want %b", n, {mem_req, gnt1, gnt0, mux_ctl, mem_we}, {1'b1, win, ~win, win, we_m[win]});
            end
            total++;
            if (mem_addr !== a_m[win] || (we_m[win] && mem_wdata !== wd_m[win])) begin
                bad++;
                $display("FAIL rnd_bus%0d: got %h/%h want %h/%h", n, mem_addr, mem_wdata, a_m[win], wd_m[win]);
            end
            d = int'($urandom_range(0, 3));
            for (int c = 0; c < d; c++) begin
                tick();
                total++;
                if ({mem_req, done0, done1, gnt1, gnt0} !== {3'b100, win, ~win}) begin
                    bad++;
                    $display("FAIL rnd_hold%0d: got %b want %b", n, {mem_req, done0, done1, gnt1, gnt0}, {3'b100, win, ~win});
                end
            end
            r = $urandom;
            mem_ack = 1; mem_rdata = r;
            tick();
            exp_rdata = r;
            m_last = win;
            total++;
            if ({done1, done0, mem_req, mem_we} !== {win, ~win, 2'b00} || rdata !== exp_rdata) begin
                bad++;
                $display("FAIL rnd_done%0d: got %b/%h want %b/%h", n, {done1, done0, mem_req, mem_we}, rdata, {win, ~win, 2'b00}, exp_rdata);
            end
            p[win] = 0;
            if (win) req1 = 0; else req0 = 0;
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            tick();
            mem_ack = 0;
            total++;
            if ({done0, done1, mem_req, gnt0, gnt1} !== 5'b0 || rdata !== exp_rdata) begin
                bad++;
                $display("FAIL rnd_after%0d: got %b/%h want 00000/%h", n, {done0, done1, mem_req, gnt0, gnt1}, rdata, exp_rdata);
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_store();
        test_stray_ack();
        test_back_to_back_tie();
        test_no_preempt();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
